// File: rtl/ct_spsram_256x23_ctrl.sv
// Access controller for the 256x23 single-port SRAM: init/flush sweep, two-way
// round-robin arbitration, and read-data return with per-requester valid.
module ct_spsram_256x23_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 23,
    parameter int                    DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [DATA_WIDTH-1:0] wmask0,
    input  logic [DATA_WIDTH-1:0] wmask1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rdata_vld0,
    output logic                  rdata_vld1,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  flush_req,
    output logic                  init_done,
    output logic                  flush_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                    state, state_nxt;
    logic [ADDR_WIDTH-1:0]     init_cnt, init_cnt_nxt;
    logic                      rr, rr_nxt;
    logic                      rd_pend, rd_pend_nxt;
    logic                      rd_id, rd_id_nxt;
    logic [1:0]                gnt;
    logic                      sel;

    logic [1:0]                 req, wr;
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][DATA_WIDTH-1:0] wdata, wmask;

    assign req   = {req1, req0};
    assign wr    = {wr1, wr0};
    assign addr  = {addr1, addr0};
    assign wdata = {wdata1, wdata0};
    assign wmask = {wmask1, wmask0};

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            rr       <= 1'b0;
            rd_pend  <= 1'b0;
            rd_id    <= 1'b0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            rr       <= rr_nxt;
            rd_pend  <= rd_pend_nxt;
            rd_id    <= rd_id_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        rr_nxt       = rr;
        rd_pend_nxt  = 1'b0;
        rd_id_nxt    = rd_id;
        gnt          = '0;
        sel          = 1'b0;
        sram_cen     = 1'b1;
        sram_gwen    = 1'b1;
        sram_wen     = '1;
        sram_a       = '0;
        sram_d       = '0;
        flush_done   = 1'b0;
        case (state)
            ST_INIT: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = init_cnt;
                sram_d    = INIT_DATA;
                // A flush mid-sweep restarts from 0 and suppresses the done pulse
                if (flush_req) begin
                    init_cnt_nxt = '0;
                end else if (init_cnt == LAST) begin
                    state_nxt    = ST_RUN;
                    init_cnt_nxt = '0;
                    flush_done   = 1'b1;
                end else begin
                    init_cnt_nxt = init_cnt + ADDR_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (flush_req) begin
                    state_nxt    = ST_INIT;
                    init_cnt_nxt = '0;
                end else if (|req) begin
                    if (&req) begin
                        sel    = rr;
                        rr_nxt = ~rr;
                    end else begin
                        sel = req[1];
                    end
                    gnt[sel]    = 1'b1;
                    sram_cen    = 1'b0;
                    sram_a      = addr[sel];
                    sram_gwen   = ~wr[sel];
                    sram_wen    = wr[sel] ? ~wmask[sel] : '1;
                    sram_d      = wdata[sel];
                    rd_pend_nxt = ~wr[sel];
                    rd_id_nxt   = sel;
                end
            end
            default: ;
        endcase
        if (!cpurst_b) begin
            gnt        = '0;
            sram_cen   = 1'b1;
            sram_gwen  = 1'b1;
            sram_wen   = '1;
            flush_done = 1'b0;
        end
    end

    assign gnt0       = gnt[0];
    assign gnt1       = gnt[1];
    assign init_done  = cpurst_b && (state == ST_RUN);
    assign rdata_vld0 = cpurst_b && rd_pend && !rd_id;
    assign rdata_vld1 = cpurst_b && rd_pend && rd_id;
    assign rdata      = sram_q;

endmodule

// File: tb/tb_ct_spsram_256x23_ctrl.sv
// Randomized bench for ct_spsram_256x23_ctrl: behavioural SRAM plus an
// array-based reference model of memory contents, arbitration and sweep timing.
module tb_ct_spsram_256x23_ctrl;
    localparam int AW    = 8;
    localparam int DW    = 23;
    localparam int DEPTH = 256;
    localparam logic [DW-1:0] INIT = '0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, wr0, wr1, flush;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, wmask0, wmask1;
    logic          gnt0, gnt1, rdata_vld0, rdata_vld1, init_done, flush_done;
    logic [DW-1:0] rdata;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;

    always #5 clk = ~clk;

    ct_spsram_256x23_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_DATA(INIT)
    ) dut (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .wmask0(wmask0), .wmask1(wmask1), .gnt0(gnt0), .gnt1(gnt1),
        .rdata_vld0(rdata_vld0), .rdata_vld1(rdata_vld1), .rdata(rdata),
        .flush_req(flush), .init_done(init_done), .flush_done(flush_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    // Behavioural SRAM: bit-masked write, registered read
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    // Reference model
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_init, m_rr, m_rd_pend, m_rd_id;
    int            m_cnt;
    logic [DW-1:0] m_rd_data;
    bit            exp_g0, exp_g1, exp_cen, exp_gwen, exp_fd, last_g0, last_g1;
    logic [DW-1:0] exp_wen, exp_d;
    logic [AW-1:0] exp_a;
    int            n_tests, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: check combinational outputs at the falling edge, then advance model.
    task automatic tick();
        bit g;
        #4;
        exp_g0 = 0; exp_g1 = 0; exp_cen = 1; exp_gwen = 1; exp_wen = '1;
        exp_a = '0; exp_d = '0; exp_fd = 0;
        if (rst_n) begin
            if (m_init) begin
                exp_cen = 0; exp_gwen = 0; exp_wen = '0;
                exp_a = AW'(m_cnt); exp_d = INIT;
                exp_fd = (m_cnt == DEPTH - 1) && !flush;
            end else if (!flush) begin
                if (req0 && req1) begin
                    exp_g0 = !m_rr; exp_g1 = m_rr;
                end else begin
                    exp_g0 = req0; exp_g1 = req1;
                end
                if (exp_g0 || exp_g1) begin
                    exp_cen  = 0;
                    exp_gwen = exp_g1 ? !wr1 : !wr0;
                    exp_a    = exp_g1 ? addr1 : addr0;
                    exp_d    = exp_g1 ? wdata1 : wdata0;
                    exp_wen  = (exp_g1 ? wr1 : wr0) ? ~(exp_g1 ? wmask1 : wmask0) : '1;
                end
            end
        end
        chk("gnt0", gnt0, exp_g0);
        chk("gnt1", gnt1, exp_g1);
        chk("sram_cen", sram_cen, exp_cen);
        chk("sram_gwen", sram_gwen, exp_gwen);
        chk("sram_wen", sram_wen, exp_wen);
        chk("flush_done", flush_done, exp_fd);
        chk("init_done", init_done, rst_n && !m_init);
        chk("rdata_vld0", rdata_vld0, rst_n && m_rd_pend && !m_rd_id);
        chk("rdata_vld1", rdata_vld1, rst_n && m_rd_pend && m_rd_id);
        if (!exp_cen) begin
            chk("sram_a", sram_a, exp_a);
            chk("sram_d", sram_d, exp_d);
        end
        if (rst_n && m_rd_pend) chk("rdata", rdata, m_rd_data);

        if (!rst_n) begin
            m_init = 1; m_cnt = 0; m_rr = 0; m_rd_pend = 0; m_rd_id = 0;
        end else begin
            m_rd_pend = 0;
            if (m_init) begin
                ref_mem[m_cnt] = INIT;
                if (flush) m_cnt = 0;
                else if (m_cnt == DEPTH - 1) begin m_init = 0; m_cnt = 0; end
                else m_cnt++;
            end else if (flush) begin
                m_init = 1; m_cnt = 0;
            end else if (exp_g0 || exp_g1) begin
                g = exp_g1;
                if (req0 && req1) m_rr = !g;
                if (g ? wr1 : wr0) begin
                    ref_mem[exp_a] = (ref_mem[exp_a] & ~(g ? wmask1 : wmask0)) |
                                     ((g ? wdata1 : wdata0) & (g ? wmask1 : wmask0));
                end else begin
                    m_rd_pend = 1; m_rd_id = g; m_rd_data = ref_mem[exp_a];
                end
            end
        end
        last_g0 = exp_g0; last_g1 = exp_g1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit n, input bit r, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
        if (n) begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; wmask1 = m; end
        else   begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; wmask0 = m; end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; last_g0 = 0; last_g1 = 0;
        m_init = 1; m_cnt = 0; m_rr = 0; m_rd_pend = 0; m_rd_id = 0; m_rd_data = '0;
        rst_n = 0; flush = 0;
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, '0, '0, '0);
        repeat (3) tick();
        rst_n = 1;

        // Init sweep with requests asserted at random: none may be granted
        for (int c = 0; c < DEPTH; c++) begin
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            tick();
        end
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, '0, '0, '0);
        chk("init_done_after_sweep", init_done, 1);

        // Masked write then read-back
        set_req(0, 1, 1, 8'h5A, 23'h7FFFFF, 23'h00000F);
        tick();
        set_req(0, 1, 0, 8'h5A, '0, '0);
        tick();
        set_req(0, 0, 0, '0, '0, '0);
        chk("wr_rd_vld0", rdata_vld0, 1);
        chk("wr_rd_data", rdata, 23'h00000F);
        tick();

        // Contention then lone requester 1
        set_req(0, 1, 0, 8'h10, '0, '0);
        set_req(1, 1, 0, 8'h5A, '0, '0);
        repeat (4) tick();
        set_req(0, 0, 0, '0, '0, '0);
        tick();
        set_req(1, 0, 0, '0, '0, '0);

        // Alternating reads from both requesters
        for (int i = 0; i < 6; i++) begin
            set_req(0, (i % 2) == 0, 0, AW'(i + 80), '0, '0);
            set_req(1, (i % 2) == 1, 0, AW'(i + 80), '0, '0);
            tick();
        end
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, '0, '0, '0);

        // Flush in RUN with a read pending
        set_req(0, 1, 0, 8'h5A, '0, '0);
        tick();
        set_req(0, 0, 0, '0, '0, '0);
        flush = 1;
        tick();
        flush = 0;
        chk("flush_sweep_addr0", sram_a, 0);
        repeat (DEPTH + 1) tick();

        // Flush mid-sweep at init_cnt 100, then reset mid-sweep
        flush = 1;
        tick();
        flush = 0;
        for (int k = 0; k < 300 && m_cnt != 100; k++) tick();
        chk("sweep_at_100", sram_a, 100);
        flush = 1;
        tick();
        flush = 0;
        chk("flush_restart_addr", sram_a, 0);
        repeat (50) tick();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        chk("reset_restart_addr", sram_a, 0);
        repeat (DEPTH + 1) tick();

        // Random traffic: requests held until granted, occasional flushes
        for (int c = 0; c < 1500; c++) begin
            if (!req0 || last_g0)
                set_req(0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom));
            if (!req1 || last_g1)
                set_req(1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom));
            flush = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
